dbg_cap: RTL

- Capture engine on the far end of the debug logic-analyzer tap.
- Consumes the 128-bit packed pipeline probe vector (ctl/mic/dfe/aco/wrd bit layout) that the debug mux drives toward the analyzer.
- Waits for a masked match trigger, then records DEPTH consecutive probe samples into an on-chip buffer.
- Plays the samples back over a valid/ready read port so firmware can inspect wake-word pipeline traffic without external LA pins.

---
 rtl/dbg_pkg.sv | 27 ++
 rtl/dbg_cap_mem.sv | 38 +++
 rtl/dbg_cap.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/dbg_pkg.sv
// Shared definitions for the debug capture engine: state encoding and the
// bit map of the packed pipeline probe vector.
package dbg_pkg;

    localparam int DBG_PROBE_BW = 128;

    typedef enum logic [1:0] {
        DBG_CAP_IDLE    = 2'd0,
        DBG_CAP_ARMED   = 2'd1,
        DBG_CAP_CAPTURE = 2'd2,
        DBG_CAP_DONE    = 2'd3
    } dbg_cap_state_e;

    // Probe vector field positions, shared with firmware decode
    localparam int DBG_CTL_BIT      = 0;
    localparam int DBG_MIC_BIT      = 1;
    localparam int DBG_DFE_LSB      = 2;
    localparam int DBG_DFE_MSB      = 9;
    localparam int DBG_DFE_VLD_BIT  = 10;
    localparam int DBG_ACO_LSB      = 11;
    localparam int DBG_ACO_MSB      = 114;
    localparam int DBG_ACO_VLD_BIT  = 115;
    localparam int DBG_ACO_LAST_BIT = 116;
    localparam int DBG_WRD_WAKE_BIT = 117;
    localparam int DBG_WRD_VLD_BIT  = 118;

endpackage

// File: rtl/dbg_cap_mem.sv
// Sample buffer for the capture engine: one write port and one registered
// read port, kept separate so an SRAM macro can replace it.
module dbg_cap_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 128,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Array contents are deliberately left out of reset
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dbg_cap.sv
// Logic-analyzer capture engine: masked-match trigger, DEPTH-sample capture
// and valid/ready playback. DBG_CAP_DECIM_EN adds capture decimation (decim_i).
module dbg_cap
    import dbg_pkg::*;
#(
    parameter int PROBE_BW = DBG_PROBE_BW,
    parameter int DEPTH    = 16,
    localparam int CNT_BW  = $clog2(DEPTH) + 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [PROBE_BW-1:0] probe_i,
    input  logic                arm_i,
    input  logic [PROBE_BW-1:0] trig_mask_i,
    input  logic [PROBE_BW-1:0] trig_value_i,
    output logic [1:0]          state_o,
    output logic                trig_o,
    output logic [CNT_BW-1:0]   wr_cnt_o,
    output logic [PROBE_BW-1:0] rd_data_o,
    output logic                rd_valid_o,
    input  logic                rd_ready_i
`ifdef DBG_CAP_DECIM_EN
    ,
    input  logic [7:0]          decim_i
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_BW-1:0] LAST_C = CNT_BW'(DEPTH - 1);
    localparam logic [CNT_BW-1:0] ONE_C  = CNT_BW'(1);

    dbg_cap_state_e    state_q, state_d;
    logic [CNT_BW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_BW-1:0] rd_ptr_q, rd_ptr_d;
    logic              trig_q, trig_d;
    logic              hit, store, accept, wr_en, rd_en;

    assign hit    = ((probe_i ^ trig_value_i) & trig_mask_i) == '0;
    assign accept = (state_q == DBG_CAP_DONE) & rd_ready_i;

`ifdef DBG_CAP_DECIM_EN
    logic [7:0] div_q, div_d;

    // >= keeps the divider from running away if decim_i shrinks mid-capture
    assign store = (state_q == DBG_CAP_CAPTURE) && (div_q >= decim_i);

    always_comb begin
        div_d = div_q + 8'd1;
        if (arm_i || (state_q != DBG_CAP_CAPTURE) || store) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end
`else
    assign store = (state_q == DBG_CAP_CAPTURE);
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= DBG_CAP_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (arm_i) begin
            state_d = DBG_CAP_ARMED;
        end else begin
            case (state_q)
                DBG_CAP_ARMED:   if (hit) state_d = DBG_CAP_CAPTURE;
                DBG_CAP_CAPTURE: if (store && (wr_cnt_q == LAST_C)) state_d = DBG_CAP_DONE;
                DBG_CAP_DONE:    if (accept && (rd_ptr_q == LAST_C)) state_d = DBG_CAP_IDLE;
                default:         state_d = state_q;
            endcase
        end
    end

    always_comb begin
        wr_en    = 1'b0;
        trig_d   = 1'b0;
        wr_cnt_d = wr_cnt_q;
        rd_ptr_d = rd_ptr_q;
        if (arm_i) begin
            wr_cnt_d = '0;
            rd_ptr_d = '0;
        end else begin
            trig_d = (state_q == DBG_CAP_ARMED) && hit;
            if (trig_d || store) begin
                wr_en    = 1'b1;
                wr_cnt_d = wr_cnt_q + ONE_C;
            end
            if (accept) begin
                rd_ptr_d = rd_ptr_q + ONE_C;
            end
        end
        state_o    = state_q;
        trig_o     = trig_q;
        wr_cnt_o   = wr_cnt_q;
        rd_valid_o = (state_q == DBG_CAP_DONE);
    end

    // Prefetch the sample the next cycle will present, so data and valid rise together
    assign rd_en = (state_d == DBG_CAP_DONE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_cnt_q <= '0;
            rd_ptr_q <= '0;
            trig_q   <= 1'b0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_ptr_q <= rd_ptr_d;
            trig_q   <= trig_d;
        end
    end

    dbg_cap_mem #(
        .DEPTH (DEPTH),
        .WIDTH (PROBE_BW)
    ) u_mem (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (wr_en),
        .waddr_i (wr_cnt_q[AW-1:0]),
        .wdata_i (probe_i),
        .re_i    (rd_en),
        .raddr_i (rd_ptr_d[AW-1:0]),
        .rdata_o (rd_data_o)
    );

endmodule
